// File: rtl/audio_clk_pkg.sv
// Shared types and defaults for the audio serial-clock generator.
// Imported by the divider stages and the top level.
package audio_clk_pkg;

   localparam int DEF_DIV_W  = 8;
   localparam int DEF_SLOT_W = 6;

   typedef struct packed {
      logic [DEF_DIV_W-1:0]  div;
      logic [DEF_SLOT_W-1:0] slot;
   } cfg_t;

   // 4-clk BCLK, 32-bit slots
   localparam cfg_t DEFAULT_CFG = '{
      div:  DEF_DIV_W'(1),
      slot: DEF_SLOT_W'(31)
   };

   function automatic cfg_t make_cfg(
      input logic [DEF_DIV_W-1:0]  d,
      input logic [DEF_SLOT_W-1:0] s
   );
      cfg_t c;
      c.div  = d;
      c.slot = s;
      return c;
   endfunction

endpackage

// File: rtl/audio_clk_gen_toggle_div.sv
// Terminal-count divider that toggles a level on each wrap.
// Rise/fall strobes are registered with the new level.
module toggle_div #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic [W-1:0] term,
   output logic         level,
   output logic         rise,
   output logic         fall,
   output logic [W-1:0] cnt
);

   logic hit;

   assign hit = (cnt == term);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (step) begin
            if (hit) begin
               cnt   <= '0;
               level <= ~level;
               rise  <= ~level;
               fall  <= level;
            end else begin
               cnt <= cnt + W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/audio_clk_gen.sv
// BCLK/LRCLK generator with shadowed ratios that switch
// only on the frame boundary, so no runt pulse can appear.
module audio_clk_gen
   import audio_clk_pkg::*;
#(
   parameter int DIV_W  = DEF_DIV_W,
   parameter int SLOT_W = DEF_SLOT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  half_div,
   input  logic [SLOT_W-1:0] slot_bits,
   input  logic              load,
   output logic              bclk,
   output logic              bclk_rise,
   output logic              bclk_fall,
   output logic              lrclk,
   output logic              frame_start,
   output logic [SLOT_W-1:0] bit_idx,
   output logic              load_ack
);

   logic [DIV_W-1:0]  cfg_div;
   logic [SLOT_W-1:0] cfg_slot;
   logic [DIV_W-1:0]  sh_div;
   logic [SLOT_W-1:0] sh_slot;
   logic              pending;
   logic [DIV_W-1:0]  div_cnt;
   logic              lr_step;
   logic              boundary;
   logic              lr_rise_unused;

   // bclk is about to fall / lrclk is about to fall on this edge
   assign lr_step  = en & bclk & (div_cnt == cfg_div);
   assign boundary = lr_step & lrclk & (bit_idx == cfg_slot);

   toggle_div #(.W(DIV_W)) u_bclk (
      .clk   (clk),
      .rst   (rst),
      .step  (en),
      .term  (cfg_div),
      .level (bclk),
      .rise  (bclk_rise),
      .fall  (bclk_fall),
      .cnt   (div_cnt)
   );

   toggle_div #(.W(SLOT_W)) u_lrclk (
      .clk   (clk),
      .rst   (rst),
      .step  (lr_step),
      .term  (cfg_slot),
      .level (lrclk),
      .rise  (lr_rise_unused),
      .fall  (frame_start),
      .cnt   (bit_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_div  <= half_div;
         cfg_slot <= slot_bits;
         sh_div   <= half_div;
         sh_slot  <= slot_bits;
         pending  <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= boundary & pending;
         if (boundary && pending) begin
            cfg_div  <= sh_div;
            cfg_slot <= sh_slot;
         end
         // a load on the boundary edge stays pending for the next one
         if (load) begin
            sh_div  <= half_div;
            sh_slot <= slot_bits;
            pending <= 1'b1;
         end else if (boundary) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen: vector table plus
// hand-written reconfiguration and reset sequences.
module tb_audio_clk_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] half_div;
   logic [5:0] slot_bits;
   logic       load;
   logic       bclk;
   logic       bclk_rise;
   logic       bclk_fall;
   logic       lrclk;
   logic       frame_start;
   logic [5:0] bit_idx;
   logic       load_ack;

   int ncmp = 0;
   int nerr = 0;

   typedef struct {
      int   tid;
      int   cyc;
      logic bclk;
      logic rise;
      logic fall;
      logic lr;
      logic fs;
      int   bidx;
      logic ack;
   } vec_t;

   vec_t vt[$];

   audio_clk_gen u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .half_div    (half_div),
      .slot_bits   (slot_bits),
      .load        (load),
      .bclk        (bclk),
      .bclk_rise   (bclk_rise),
      .bclk_fall   (bclk_fall),
      .lrclk       (lrclk),
      .frame_start (frame_start),
      .bit_idx     (bit_idx),
      .load_ack    (load_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int hd, input int sb);
      half_div  = hd[7:0];
      slot_bits = sb[5:0];
      en        = 1'b1;
      load      = 1'b0;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_vec(input vec_t v);
      string p;
      p = $sformatf("t%0d c%0d", v.tid, v.cyc);
      chk({p, " bclk"}, 32'(bclk), 32'(v.bclk));
      chk({p, " rise"}, 32'(bclk_rise), 32'(v.rise));
      chk({p, " fall"}, 32'(bclk_fall), 32'(v.fall));
      chk({p, " lrclk"}, 32'(lrclk), 32'(v.lr));
      chk({p, " fs"}, 32'(frame_start), 32'(v.fs));
      chk({p, " bidx"}, 32'(bit_idx), 32'(v.bidx));
      chk({p, " ack"}, 32'(load_ack), 32'(v.ack));
   endtask

   task automatic run_table(input int tid, input int hd,
                            input int sb, input int last);
      do_reset(hd, sb);
      for (int n = 0; n <= last; n++) begin
         if (n > 0) tick();
         foreach (vt[i])
            if (vt[i].tid == tid && vt[i].cyc == n)
               chk_vec(vt[i]);
      end
   endtask

   // loads before edges l1/l2; new ratio expected from edge ack_n
   task automatic seq_cfg(input string nm, input int l1, input int h1,
                          input int l2, input int h2, input int ack_n,
                          input int new_half, input int last);
      int acks;
      logic expb;
      acks = 0;
      do_reset(1, 3);
      for (int n = 1; n <= last; n++) begin
         load = 1'b0;
         if (n == l1) begin
            load = 1'b1;
            half_div = h1[7:0];
         end
         if (n == l2) begin
            load = 1'b1;
            half_div = h2[7:0];
         end
         tick();
         if (load) begin
            load = 1'b0;
            half_div = 8'd9;
         end
         if (load_ack === 1'b1) acks++;
         if (n == ack_n) begin
            chk({nm, " fs at boundary"}, 32'(frame_start), 32'd1);
            chk({nm, " ack at boundary"}, 32'(load_ack), 32'd1);
         end
         if (n < ack_n) expb = ((n % 4) >= 2);
         else expb = (((n - ack_n) / (new_half + 1)) % 2) == 1;
         chk($sformatf("%s bclk c%0d", nm, n), 32'(bclk), 32'(expb));
      end
      chk({nm, " ack count"}, 32'(acks), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      load = 1'b0;
      half_div = 8'd1;
      slot_bits = 6'd3;

      //            tid cyc bclk r f lr fs bidx ack
      vt.push_back('{1, 0,  0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 1,  0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 2,  1, 1, 0, 0, 0, 0, 0});
      vt.push_back('{1, 3,  1, 0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 4,  0, 0, 1, 0, 0, 1, 0});
      vt.push_back('{1, 15, 1, 0, 0, 0, 0, 3, 0});
      vt.push_back('{1, 16, 0, 0, 1, 1, 0, 0, 0});
      vt.push_back('{1, 31, 1, 0, 0, 1, 0, 3, 0});
      vt.push_back('{1, 32, 0, 0, 1, 0, 1, 0, 0});
      vt.push_back('{1, 33, 0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{2, 0,  0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{2, 1,  1, 1, 0, 0, 0, 0, 0});
      vt.push_back('{2, 2,  0, 0, 1, 1, 0, 0, 0});
      vt.push_back('{2, 3,  1, 1, 0, 1, 0, 0, 0});
      vt.push_back('{2, 4,  0, 0, 1, 0, 1, 0, 0});
      vt.push_back('{2, 5,  1, 1, 0, 0, 0, 0, 0});

      run_table(1, 1, 3, 33);
      run_table(2, 0, 0, 5);

      // hold for 5 edges while bclk is high, mid half-period
      do_reset(1, 3);
      tick();
      tick();
      chk("hold pre rise", 32'(bclk_rise), 32'd1);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold bclk", 32'(bclk), 32'd1);
         chk("hold strobes", 32'({bclk_rise, bclk_fall}), 32'd0);
         chk("hold bidx", 32'(bit_idx), 32'd0);
      end
      en = 1'b1;
      tick();
      chk("resume bclk", 32'(bclk), 32'd1);
      chk("resume nofall", 32'(bclk_fall), 32'd0);
      tick();
      chk("resume fall", 32'(bclk_fall), 32'd1);
      chk("resume bidx", 32'(bit_idx), 32'd1);
      tick();
      tick();
      chk("resume rise", 32'(bclk_rise), 32'd1);

      seq_cfg("one load", 11, 2, -1, 0, 32, 2, 50);
      seq_cfg("two loads", 11, 2, 21, 4, 32, 4, 60);
      seq_cfg("load on fs", 32, 2, -1, 0, 64, 2, 75);

      // reset discards a pending request
      do_reset(1, 3);
      for (int n = 1; n <= 20; n++) begin
         load = (n == 11);
         half_div = (n == 11) ? 8'd2 : 8'd1;
         tick();
      end
      load = 1'b0;
      half_div = 8'd1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst bclk", 32'(bclk), 32'd0);
      chk("rst lrclk", 32'(lrclk), 32'd0);
      chk("rst bidx", 32'(bit_idx), 32'd0);
      chk("rst strobes", 32'({bclk_rise, bclk_fall, frame_start}), 32'd0);
      for (int n = 1; n <= 70; n++) begin
         tick();
         chk($sformatf("post-rst ack c%0d", n), 32'(load_ack), 32'd0);
         chk($sformatf("post-rst bclk c%0d", n), 32'(bclk),
             32'((n % 4) >= 2));
         if (n == 32 || n == 64)
            chk($sformatf("post-rst fs c%0d", n), 32'(frame_start), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/audio_clk_gen.md
Name: audio_clk_gen

Overview:
Programmable audio serial-clock generator that produces BCLK and LRCLK levels plus single-cycle edge strobes from the system clock.
- Generalises the fixed power-of-two divider: arbitrary integer ratios, a second (frame) division stage, a bit index, enable/hold, and glitch-free runtime reconfiguration at frame boundaries.
- Feeds the I2S transmit/receive shifters and the mixer frame scheduler.

Parameters:
DIV_W, 8, width of half_div; BCLK half-period = half_div+1 clk cycles
SLOT_W, 6, width of slot_bits/bit_idx; LRCLK half-frame = slot_bits+1 BCLK periods

Ports:
clk  in  1  system clock
rst  in  1  reset (synchronous, active-high)
en  in  1  advance enable; 0 freezes all state
half_div  in  DIV_W  requested BCLK half-period minus 1
slot_bits  in  SLOT_W  requested BCLK periods per half-frame minus 1
load  in  1  capture half_div/slot_bits into shadow; applied at next frame boundary
bclk  out  1  bit clock level
bclk_rise  out  1  1-cycle strobe, first cycle bclk==1
bclk_fall  out  1  1-cycle strobe, first cycle bclk==0
lrclk  out  1  word clock; 0 = left, 1 = right
frame_start  out  1  1-cycle strobe, first cycle lrclk==0 after a 1→0 change
bit_idx  out  SLOT_W  BCLK period index within current half-frame
load_ack  out  1  1-cycle strobe when shadow config becomes active

Behaviour:
- Reset (clock edge with rst=1):
  - div_cnt=0, bit_idx=0, bclk=0, lrclk=0; all strobes 0; pending=0.
  - Active cfg is loaded directly from half_div/slot_bits.
- All outputs are registered. Strobes are coincident with the new level, never with the old one.
- en=0: counters, levels and shadow state hold; strobes are 0. load is still captured.
- Divider stage:
  - Each enabled cycle: if div_cnt==cfg_div, then div_cnt←0 and bclk toggles; else div_cnt+1.
  - BCLK period = 2·(cfg_div+1) clk.
  - cfg_div=0 gives a toggle every enabled cycle.
- Slot stage: advances only on the cycle bclk toggles 1→0.
  - If bit_idx==cfg_slot, then bit_idx←0 and lrclk toggles; else bit_idx+1.
  - lrclk therefore changes in the same cycle as bclk_fall.
  - LRCLK period = 2·(cfg_slot+1) BCLK periods.
- frame_start pulses in the cycle lrclk becomes 0 (it does not pulse at reset exit).
- Reconfiguration:
  - load=1 (en irrelevant): shadow←{half_div, slot_bits}, pending←1. A later load before application overwrites the shadow; the latest value wins.
  - At the boundary edge that produces frame_start with pending=1: cfg←shadow, pending←0, load_ack=1 in the same cycle as frame_start.
  - The new ratios govern from the next cycle. div_cnt and bit_idx are already 0, so no runt pulse is possible.
  - load in the same cycle as a boundary: the boundary applies the old shadow (if pending); the new values are captured and stay pending for the next boundary.
- Changing half_div/slot_bits inputs without load has no effect.
- rst mid-operation: immediate return to the reset state on that edge. A pending request is discarded, with no load_ack.
- Counter compares use equality only. No overflow is possible because the counters never exceed their cfg value.

Decomposition:
- Package audio_clk_pkg:
  - typedef struct cfg_t {div, slot}
  - DIV_W/SLOT_W defaults
  - DEFAULT_CFG constant
- Sub-module toggle_div: parametric width.
  - Inputs: step enable, terminal value.
  - Outputs: level, rise, fall strobes, count.
  - Instantiated twice: for BCLK, step=en; for LRCLK, step=en&bclk falling-transition.
- The top level holds the shadow/pending/ack logic and the frame_start derivation.

Test Plan:
- Reset release with half_div=1, slot_bits=3, en=1:
  - first bclk rise 2 clk after reset deassertion; period 4 clk.
  - lrclk half-frame 16 clk, frame 32 clk.
  - bit_idx cycles 0..3.
- half_div=0, slot_bits=0 → bclk toggles every clk; lrclk toggles every 2 clk, aligned with bclk_fall.
- en toggled low for 5 cycles mid-half-period → all outputs frozen, no strobes, phase resumes exactly.
- Config change:
  - load half_div=2 mid-frame → old 4-clk BCLK continues until frame_start.
  - load_ack coincident with frame_start; BCLK period is then 6 clk.
  - no pulse shorter than 3 clk.
- Two loads (half_div=2, then 4) before a boundary → only 4 is applied, single load_ack.
- load asserted exactly on the frame_start cycle → no ack on that boundary; ack on the following boundary.
- rst asserted with pending load → outputs return to the reset state; no load_ack afterwards.
